dma_hold_arbiter: RTL and testbench

Bus-side responder to the DMA HOLD/HLDA handshake. Accepts the DMA engine's HOLD request and asks the processor to release the bus. Once the processor acknowledges, it grants HLDA to the DMA and later hands the bus back. It sits between the DMA engine and the processor, so the top-level controller no longer drives the DMA's HLDA directly.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_gap_counter.sv | 28 ++
 rtl/dma_hold_arbiter.sv | 141 ++++++++++++++
 tb/tb_dma_hold_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: state encoding and defaults shared by the DMA hold arbiter.
package dma_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_GRANT  = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    localparam int DEF_CNT_W = 8;
    localparam int GAP_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_REQ    = ST_REQ,
        S_GRANT  = ST_GRANT,
        S_RETURN = ST_RETURN
    } state_t;

endpackage

// File: rtl/dma_gap_counter.sv
// dma_gap_counter: loadable down-counter that stops at zero.
module dma_gap_counter
    import dma_pkg::*;
#(
    parameter int W = GAP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dma_hold_arbiter.sv
// dma_hold_arbiter: HOLD/HLDA responder between a DMA engine and the CPU.
// Optional grant-length limit with abort pulse: define ARB_TIMEOUT_EN.
module dma_hold_arbiter
    import dma_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int MAX_GRANT  = 64,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dma_hold,
    output logic             dma_hlda,
    output logic             cpu_hold,
    input  logic             cpu_hlda,
    output logic             bus_owner,
    output logic [CNT_W-1:0] grant_cycles,
    output logic             abort
);

    localparam logic [CNT_W-1:0] GC_MAX = '1;

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
        MAX_GRANT < 1 || MAX_GRANT > 255) begin : g_param_chk
        $error("dma_hold_arbiter: parameter out of range");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_gap_zero;
    logic             w_gap_load;
    logic             w_timeout;
    logic             w_block;
    logic             r_dma_hlda;
    logic             r_cpu_hold;
    logic             r_bus_owner;
    logic             r_abort;
    logic [CNT_W-1:0] r_gc;

`ifdef ARB_TIMEOUT_EN
    localparam int LIM = MAX_GRANT - 1;
    logic r_need_low;

    assign w_timeout = (r_state == S_GRANT) && dma_hold &&
                       (32'(r_gc) == LIM);

    // an aborted master must drop HOLD once before it may win again
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_need_low <= 1'b0;
        end else if (w_timeout) begin
            r_need_low <= 1'b1;
        end else if (!dma_hold) begin
            r_need_low <= 1'b0;
        end
    end

    assign w_block = r_need_low;
`else
    assign w_timeout = 1'b0;
    assign w_block   = 1'b0;
`endif

    assign w_gap_load = (r_state == S_RETURN) && !cpu_hlda;

    dma_gap_counter #(
        .W(GAP_W)
    ) u_gap (
        .clk    (clock),
        .rst_n  (reset_n),
        .i_load (w_gap_load),
        .i_value(GAP_W'(GAP_CYCLES)),
        .o_zero (w_gap_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (dma_hold && w_gap_zero && !w_block) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!dma_hold) begin
                    w_next = S_RETURN;
                end else if (cpu_hlda) begin
                    w_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!dma_hold || !cpu_hlda || w_timeout) begin
                    w_next = S_RETURN;
                end
            end
            S_RETURN: begin
                if (!cpu_hlda) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // outputs follow the state being entered, so they change on that edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dma_hlda  <= 1'b0;
            r_cpu_hold  <= 1'b0;
            r_bus_owner <= 1'b0;
            r_abort     <= 1'b0;
            r_gc        <= '0;
        end else begin
            r_dma_hlda  <= (w_next == S_GRANT);
            r_cpu_hold  <= (w_next == S_REQ) || (w_next == S_GRANT);
            r_bus_owner <= (w_next == S_GRANT) ||
                           ((w_next == S_RETURN) && r_bus_owner);
            r_abort     <= w_timeout;
            if ((r_state == S_REQ) && (w_next == S_GRANT)) begin
                r_gc <= '0;
            end else if ((r_state == S_GRANT) && (r_gc != GC_MAX)) begin
                r_gc <= r_gc + 1'b1;
            end
        end
    end

    assign dma_hlda     = r_dma_hlda;
    assign cpu_hold     = r_cpu_hold;
    assign bus_owner    = r_bus_owner;
    assign abort        = r_abort;
    assign grant_cycles = r_gc;

endmodule

// File: tb/tb_dma_hold_arbiter.sv
// tb_dma_hold_arbiter: directed and random checks of dma_hold_arbiter
// against a behavioural model of the HOLD/HLDA rules.
module tb_dma_hold_arbiter;

    localparam int GAP = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int MG = 8;
`else
    localparam int MG = 64;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       dma_hold;
    logic       cpu_hlda;
    logic       dma_hlda, cpu_hold, bus_owner, abort;
    logic [7:0] grant_cycles;
    logic       s_dma_hlda, s_cpu_hold, s_bus_owner, s_abort;
    logic [3:0] s_grant_cycles;

    always #5 clock = ~clock;

    dma_hold_arbiter #(
        .GAP_CYCLES(GAP), .MAX_GRANT(MG), .CNT_W(8)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .dma_hold(dma_hold),
        .dma_hlda(dma_hlda), .cpu_hold(cpu_hold), .cpu_hlda(cpu_hlda),
        .bus_owner(bus_owner), .grant_cycles(grant_cycles), .abort(abort)
    );

    dma_hold_arbiter #(
        .GAP_CYCLES(GAP), .MAX_GRANT(MG), .CNT_W(4)
    ) u_sat (
        .clock(clock), .reset_n(reset_n), .dma_hold(dma_hold),
        .dma_hlda(s_dma_hlda), .cpu_hold(s_cpu_hold), .cpu_hlda(cpu_hlda),
        .bus_owner(s_bus_owner), .grant_cycles(s_grant_cycles),
        .abort(s_abort)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // processor model: cpu_hlda echoes cpu_hold 'lag' edges later
    logic [7:0] hist = '0;
    int         lag = 1;
    bit         proc_en = 1'b1;

    // behavioural model of the bus ownership rules
    bit m_asking, m_granted, m_owns, m_returning, m_abort, m_wait_low;
    int m_gap, m_gc;

    function automatic void model_reset();
        m_asking = 0; m_granted = 0; m_owns = 0; m_returning = 0;
        m_abort = 0; m_wait_low = 0; m_gap = 0; m_gc = 0;
    endfunction

    function automatic void model_step(bit h, bit a);
        bit to;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_abort = 0;
        if (!h) m_wait_low = 0;
        if (m_returning) begin
            if (!a) begin
                m_returning = 0;
                m_owns = 0;
                m_gap = GAP;
            end
        end else if (m_granted) begin
`ifdef ARB_TIMEOUT_EN
            to = h && (m_gc == MG - 1);
`else
            to = 0;
`endif
            m_gc = m_gc + 1;
            if (!h || !a || to) begin
                m_granted = 0;
                m_asking = 0;
                m_returning = 1;
                m_abort = to;
                if (to) m_wait_low = 1;
            end
        end else if (m_asking) begin
            if (!h) begin
                m_asking = 0;
                m_returning = 1;
            end else if (a) begin
                m_granted = 1;
                m_owns = 1;
                m_gc = 0;
            end
        end else begin
            if (m_gap > 0) m_gap = m_gap - 1;
            else if (h && !m_wait_low) m_asking = 1;
        end
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [7:0] g8;
        logic [3:0] g4;
        g8 = (m_gc > 255) ? 8'hFF : 8'(m_gc);
        g4 = (m_gc > 15) ? 4'hF : 4'(m_gc);
        return {m_granted, m_asking, m_owns, m_abort, g8,
                m_granted, m_asking, m_owns, m_abort, g4};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {dma_hlda, cpu_hold, bus_owner, abort, grant_cycles,
                s_dma_hlda, s_cpu_hold, s_bus_owner, s_abort,
                s_grant_cycles};
    endfunction

    task automatic tick();
        model_step(dma_hold, cpu_hlda);
        @(posedge clock);
        #1;
        cyc++;
        hist = {hist[6:0], cpu_hold};
        if (proc_en) cpu_hlda = hist[lag];
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dma_hold = 1'b0;
        cpu_hlda = 1'b0;
        model_reset();
        #2;
        n_total++;
        if (obs_vec() !== exp_vec())
            $display("FAIL reset_async got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        repeat (3) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        #3 reset_n = 1'b1;
        repeat (2) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL reset_release cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int t_hold = -1;
        int t_hlda = -1;
        bit done = 0;
        lag = 1;
        dma_hold = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL basic_req cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (t_hold < 0 && cpu_hold) t_hold = i;
            if (dma_hlda) begin
                t_hlda = i;
                break;
            end
        end
        n_total++;
        if (t_hold !== 1)
            $display("FAIL basic_cpu_hold_latency got=%0d exp=1", t_hold);
        else n_pass++;
        n_total++;
        if (t_hlda !== 3)
            $display("FAIL basic_hlda_latency got=%0d exp=3", t_hlda);
        else n_pass++;
        repeat (16) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL basic_grant cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        dma_hold = 1'b0;
        tick();
        n_total++;
        if (dma_hlda !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL basic_release cyc=%0d got=%h exp=%h",
                     cyc, obs_vec(), exp_vec());
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL basic_return cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (!bus_owner) begin
                done = 1;
                break;
            end
        end
        n_total++;
        if (!done) $display("FAIL basic_owner_back got=1 exp=0");
        else n_pass++;
    endtask

    task automatic test_gap();
        int t_req = -1;
        dma_hold = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL gap_wait cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (cpu_hold) begin
                t_req = i;
                break;
            end
        end
        n_total++;
        if (t_req !== GAP + 1)
            $display("FAIL gap_length got=%0d exp=%0d", t_req, GAP + 1);
        else n_pass++;
        repeat (6) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL gap_grant cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        dma_hold = 1'b0;
        repeat (12) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL gap_drain cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_withdraw();
        int saved;
        int saw_hlda = 0;
        saved = (m_gc > 255) ? 255 : m_gc;
        proc_en = 1'b0;
        cpu_hlda = 1'b0;
        dma_hold = 1'b1;
        tick();
        n_total++;
        if (obs_vec() !== exp_vec())
            $display("FAIL withdraw_req cyc=%0d got=%h exp=%h",
                     cyc, obs_vec(), exp_vec());
        else n_pass++;
        dma_hold = 1'b0;
        repeat (6) begin
            tick();
            if (dma_hlda) saw_hlda++;
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL withdraw_back cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (saw_hlda !== 0 || cpu_hold !== 1'b0 ||
            int'(grant_cycles) !== saved)
            $display("FAIL withdraw_final got=hlda%0d/hold%b/gc%0d exp=0/0/%0d",
                     saw_hlda, cpu_hold, grant_cycles, saved);
        else n_pass++;
        proc_en = 1'b1;
        hist = '0;
    endtask

    task automatic test_violation();
        lag = 0;
        dma_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL viol_req cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (dma_hlda) break;
        end
        repeat (2) tick();
        proc_en = 1'b0;
        cpu_hlda = 1'b0;
        tick();
        n_total++;
        if (dma_hlda !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL viol_drop cyc=%0d got=%h exp=%h",
                     cyc, obs_vec(), exp_vec());
        else n_pass++;
        dma_hold = 1'b0;
        proc_en = 1'b1;
        repeat (8) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL viol_return cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        lag = 1;
        dma_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dma_hlda) break;
        end
        repeat (3) tick();
        n_total++;
        if (obs_vec() !== exp_vec() || !m_granted)
            $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h",
                     cyc, obs_vec(), exp_vec());
        else n_pass++;
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (obs_vec() !== exp_vec())
            $display("FAIL rstmid_async got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        dma_hold = 1'b0;
        repeat (2) tick();
        #3 reset_n = 1'b1;
        hist = '0;
        cpu_hlda = 1'b0;
        repeat (4) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL rstmid_after cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

`ifndef ARB_TIMEOUT_EN
    task automatic test_saturation();
        int aborts = 0;
        dma_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dma_hlda) break;
        end
        repeat (70) begin
            tick();
            if (abort || s_abort) aborts++;
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL sat_grant cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_total++;
        if (aborts !== 0 || dma_hlda !== 1'b1 ||
            s_grant_cycles !== 4'hF || grant_cycles !== 8'd70)
            $display("FAIL sat_values got=ab%0d/hlda%b/gc4=%0d/gc8=%0d exp=0/1/15/70",
                     aborts, dma_hlda, s_grant_cycles, grant_cycles);
        else n_pass++;
        dma_hold = 1'b0;
        repeat (8) tick();
        n_total++;
        if (s_grant_cycles !== 4'hF || bus_owner !== 1'b0)
            $display("FAIL sat_hold_after got=gc%0d/own%b exp=15/0",
                     s_grant_cycles, bus_owner);
        else n_pass++;
    endtask
`else
    task automatic test_timeout();
        int gc_at_abort = -1;
        int blocked_req = 0;
        bit regrant = 0;
        dma_hold = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL tmo_run cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (abort) begin
                gc_at_abort = int'(grant_cycles);
                break;
            end
        end
        n_total++;
        if (gc_at_abort !== MG || dma_hlda !== 1'b0)
            $display("FAIL tmo_abort got=gc%0d/hlda%b exp=%0d/0",
                     gc_at_abort, dma_hlda, MG);
        else n_pass++;
        repeat (15) begin
            tick();
            if (cpu_hold) blocked_req++;
        end
        n_total++;
        if (blocked_req !== 0)
            $display("FAIL tmo_blocked got=%0d exp=0", blocked_req);
        else n_pass++;
        dma_hold = 1'b0;
        tick();
        dma_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL tmo_regrant cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (cpu_hold) begin
                regrant = 1;
                break;
            end
        end
        n_total++;
        if (!regrant) $display("FAIL tmo_rerequest got=0 exp=1");
        else n_pass++;
        dma_hold = 1'b0;
        repeat (10) tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
            if (dma_hold) begin
                if ($urandom_range(0, 11) == 0) dma_hold = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                dma_hold = 1'b1;
            end
            if (hist == '0 && !cpu_hold) lag = $urandom_range(0, 3);
            if (cpu_hlda && $urandom_range(0, 39) == 0) cpu_hlda = 1'b0;
        end
        dma_hold = 1'b0;
        repeat (20) begin
            tick();
            n_total++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random_drain cyc=%0d got=%h exp=%h",
                         cyc, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_withdraw();
        test_violation();
        test_reset_mid();
`ifndef ARB_TIMEOUT_EN
        test_saturation();
`else
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
